byte_mem_ctrl: RTL and testbench

BYTE_MEM_CTRL -- requirements
Module: byte_mem_ctrl

---
 rtl/byte_mem_ctrl.sv | 242 ++++++++++++++++++++++++
 tb/tb_byte_mem_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/byte_mem_ctrl.sv
// Byte-addressed memory controller with independent read and write channels.
// The array is zeroed one byte per cycle after reset before any request is accepted.
module byte_mem_ctrl #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned RD_LAT = 2,
  parameter int unsigned WR_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  output logic              init_done,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [1:0]        rd_size,
  output logic              rd_busy,
  output logic              rd_ready,
  output logic [31:0]       rd_data,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [1:0]        wr_size,
  input  logic [31:0]       wr_data,
  output logic              wr_busy,
  output logic              wr_ready
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic {StInit, StRun} glb_st_e;
  typedef enum logic [1:0] {ChIdle, ChWait, ChDone} ch_st_e;

  function automatic logic [2:0] size_bytes(input logic [1:0] s);
    case (s)
      2'd1:    size_bytes = 3'd1;
      2'd2:    size_bytes = 3'd2;
      2'd3:    size_bytes = 3'd4;
      default: size_bytes = 3'd0;
    endcase
  endfunction

  // Global init sequencer
  glb_st_e           glb_st_q, glb_st_d;
  logic [ADDR_W:0]   init_cnt_q, init_cnt_d;
  logic              init_done_q, init_done_d;
  logic              init_we;

  // Read channel
  ch_st_e            rd_st_q, rd_st_d;
  logic [3:0]        rd_cnt_q, rd_cnt_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [1:0]        rd_size_q, rd_size_d;
  logic              rd_ready_q, rd_ready_d;
  logic [31:0]       rd_data_q, rd_data_d;
  logic              rd_sample;

  // Write channel
  ch_st_e            wr_st_q, wr_st_d;
  logic [3:0]        wr_cnt_q, wr_cnt_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [1:0]        wr_size_q, wr_size_d;
  logic [31:0]       wr_data_q, wr_data_d;
  logic              wr_ready_q, wr_ready_d;
  logic              wr_commit;

  // Datapath
  logic [7:0]        mem_q [DEPTH];
  logic [2:0]        rd_n, wr_n;
  logic [3:0]        wr_be;
  logic [ADDR_W-1:0] wr_baddr [4];
  logic [7:0]        wr_bdata [4];
  logic [ADDR_W-1:0] rd_baddr [4];
  logic [31:0]       rd_word;

  always_comb begin
    glb_st_d    = glb_st_q;
    init_cnt_d  = init_cnt_q;
    init_done_d = init_done_q;
    init_we     = 1'b0;
    case (glb_st_q)
      StInit: begin
        // Counter runs one past the last byte so RUN begins the cycle after the final clear.
        if (init_cnt_q == (ADDR_W + 1)'(DEPTH)) begin
          glb_st_d    = StRun;
          init_done_d = 1'b1;
        end else begin
          init_we    = 1'b1;
          init_cnt_d = init_cnt_q + 1'b1;
        end
      end
      default: glb_st_d = StRun;
    endcase
  end

  always_comb begin
    rd_st_d   = rd_st_q;
    rd_cnt_d  = rd_cnt_q;
    rd_addr_d = rd_addr_q;
    rd_size_d = rd_size_q;
    rd_sample = 1'b0;
    case (rd_st_q)
      ChIdle: begin
        if ((glb_st_q == StRun) && rd_req && (rd_size != 2'd0)) begin
          rd_addr_d = rd_addr;
          rd_size_d = rd_size;
          if (RD_LAT == 0) begin
            rd_st_d   = ChDone;
            rd_sample = 1'b1;
          end else begin
            rd_st_d  = ChWait;
            rd_cnt_d = 4'(RD_LAT - 1);
          end
        end
      end
      ChWait: begin
        if (rd_cnt_q == 4'd0) begin
          rd_st_d   = ChDone;
          rd_sample = 1'b1;
        end else begin
          rd_cnt_d = rd_cnt_q - 4'd1;
        end
      end
      default: rd_st_d = ChIdle;
    endcase
    rd_ready_d = rd_sample;
  end

  always_comb begin
    wr_st_d   = wr_st_q;
    wr_cnt_d  = wr_cnt_q;
    wr_addr_d = wr_addr_q;
    wr_size_d = wr_size_q;
    wr_data_d = wr_data_q;
    wr_commit = 1'b0;
    case (wr_st_q)
      ChIdle: begin
        if ((glb_st_q == StRun) && wr_req && (wr_size != 2'd0)) begin
          wr_addr_d = wr_addr;
          wr_size_d = wr_size;
          wr_data_d = wr_data;
          if (WR_LAT == 0) begin
            wr_st_d   = ChDone;
            wr_commit = 1'b1;
          end else begin
            wr_st_d  = ChWait;
            wr_cnt_d = 4'(WR_LAT - 1);
          end
        end
      end
      ChWait: begin
        if (wr_cnt_q == 4'd0) begin
          wr_st_d   = ChDone;
          wr_commit = 1'b1;
        end else begin
          wr_cnt_d = wr_cnt_q - 4'd1;
        end
      end
      default: wr_st_d = ChIdle;
    endcase
    wr_ready_d = wr_commit;
  end

  // Byte lanes use the next-state address/size so zero-latency settings work too.
  always_comb begin
    rd_n    = size_bytes(rd_size_d);
    wr_n    = size_bytes(wr_size_d);
    rd_word = 32'h0;
    for (int k = 0; k < 4; k++) begin
      wr_baddr[k] = wr_addr_d + ADDR_W'(k);
      wr_bdata[k] = wr_data_d[8*k +: 8];
      wr_be[k]    = wr_commit && (3'(k) < wr_n);
      rd_baddr[k] = rd_addr_d + ADDR_W'(k);
    end
    for (int k = 0; k < 4; k++) begin
      if (3'(k) < rd_n) begin
        rd_word[8*k +: 8] = mem_q[rd_baddr[k]];
        // Write-first: a byte committed on this edge wins over the stored value.
        for (int j = 0; j < 4; j++) begin
          if (wr_be[j] && (wr_baddr[j] == rd_baddr[k])) begin
            rd_word[8*k +: 8] = wr_bdata[j];
          end
        end
      end
    end
    rd_data_d = rd_sample ? rd_word : rd_data_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      glb_st_q    <= StInit;
      init_cnt_q  <= '0;
      init_done_q <= 1'b0;
      rd_st_q     <= ChIdle;
      rd_cnt_q    <= 4'd0;
      rd_addr_q   <= '0;
      rd_size_q   <= 2'd0;
      rd_ready_q  <= 1'b0;
      rd_data_q   <= 32'h0;
      wr_st_q     <= ChIdle;
      wr_cnt_q    <= 4'd0;
      wr_addr_q   <= '0;
      wr_size_q   <= 2'd0;
      wr_data_q   <= 32'h0;
      wr_ready_q  <= 1'b0;
    end else begin
      glb_st_q    <= glb_st_d;
      init_cnt_q  <= init_cnt_d;
      init_done_q <= init_done_d;
      rd_st_q     <= rd_st_d;
      rd_cnt_q    <= rd_cnt_d;
      rd_addr_q   <= rd_addr_d;
      rd_size_q   <= rd_size_d;
      rd_ready_q  <= rd_ready_d;
      rd_data_q   <= rd_data_d;
      wr_st_q     <= wr_st_d;
      wr_cnt_q    <= wr_cnt_d;
      wr_addr_q   <= wr_addr_d;
      wr_size_q   <= wr_size_d;
      wr_data_q   <= wr_data_d;
      wr_ready_q  <= wr_ready_d;
    end
  end

  // Array has no reset; INIT clears it. A pending write is dropped if reset is low.
  always_ff @(posedge clk) begin
    if (reset) begin
      if (init_we) begin
        mem_q[init_cnt_q[ADDR_W-1:0]] <= 8'h00;
      end
      for (int k = 0; k < 4; k++) begin
        if (wr_be[k]) begin
          mem_q[wr_baddr[k]] <= wr_bdata[k];
        end
      end
    end
  end

  assign init_done = init_done_q;
  assign rd_busy   = (glb_st_q != StRun) || (rd_st_q != ChIdle);
  assign wr_busy   = (glb_st_q != StRun) || (wr_st_q != ChIdle);
  assign rd_ready  = rd_ready_q;
  assign rd_data   = rd_data_q;
  assign wr_ready  = wr_ready_q;

endmodule

// File: tb/tb_byte_mem_ctrl.sv
// Directed bench for byte_mem_ctrl (ADDR_W=8, RD_LAT=2, WR_LAT=1).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_byte_mem_ctrl;

  logic        clk;
  logic        reset;
  logic        init_done;
  logic        rd_req;
  logic [7:0]  rd_addr;
  logic [1:0]  rd_size;
  logic        rd_busy;
  logic        rd_ready;
  logic [31:0] rd_data;
  logic        wr_req;
  logic [7:0]  wr_addr;
  logic [1:0]  wr_size;
  logic [31:0] wr_data;
  logic        wr_busy;
  logic        wr_ready;

  int total;
  int bad;

  byte_mem_ctrl #(
    .ADDR_W(8),
    .RD_LAT(2),
    .WR_LAT(1)
  ) u_dut (
    .clk      (clk),
    .reset    (reset),
    .init_done(init_done),
    .rd_req   (rd_req),
    .rd_addr  (rd_addr),
    .rd_size  (rd_size),
    .rd_busy  (rd_busy),
    .rd_ready (rd_ready),
    .rd_data  (rd_data),
    .wr_req   (wr_req),
    .wr_addr  (wr_addr),
    .wr_size  (wr_size),
    .wr_data  (wr_data),
    .wr_busy  (wr_busy),
    .wr_ready (wr_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Read with RD_LAT=2: ready is high in the third cycle after the request cycle.
  task automatic do_read(input logic [7:0] a, input logic [1:0] s, input logic [31:0] exp,
                         input string tag);
    rd_req  = 1'b1;
    rd_addr = a;
    rd_size = s;
    cyc(1);
    rd_req = 1'b0;
    chk1({tag, "_busy"}, rd_busy, 1'b1);
    cyc(1);
    chk1({tag, "_early"}, rd_ready, 1'b0);
    cyc(1);
    chk1({tag, "_rdy"}, rd_ready, 1'b1);
    chk32({tag, "_data"}, rd_data, exp);
    cyc(1);
    chk1({tag, "_pulse"}, rd_ready, 1'b0);
  endtask

  // Write with WR_LAT=1: ready is high in the second cycle after the request cycle.
  task automatic do_write(input logic [7:0] a, input logic [1:0] s, input logic [31:0] d,
                          input string tag);
    wr_req  = 1'b1;
    wr_addr = a;
    wr_size = s;
    wr_data = d;
    cyc(1);
    wr_req = 1'b0;
    chk1({tag, "_early"}, wr_ready, 1'b0);
    cyc(1);
    chk1({tag, "_rdy"}, wr_ready, 1'b1);
    cyc(1);
    chk1({tag, "_pulse"}, wr_ready, 1'b0);
  endtask

  initial begin
    logic busy_drop;
    logic rdy_seen;
    logic early_done;
    total   = 0;
    bad     = 0;
    reset   = 1'b0;
    rd_req  = 1'b0;
    rd_addr = 8'h00;
    rd_size = 2'd0;
    wr_req  = 1'b0;
    wr_addr = 8'h00;
    wr_size = 2'd0;
    wr_data = 32'h0;
    cyc(3);
    chk1("rst_init_done", init_done, 1'b0);
    chk1("rst_rd_busy", rd_busy, 1'b1);
    chk1("rst_wr_busy", wr_busy, 1'b1);
    chk1("rst_rd_ready", rd_ready, 1'b0);
    chk32("rst_rd_data", rd_data, 32'h0);

    // Init sweep, with requests thrown at it that must be ignored.
    reset      = 1'b1;
    busy_drop  = 1'b0;
    rdy_seen   = 1'b0;
    early_done = 1'b0;
    for (int i = 0; i < 256; i++) begin
      if (i == 10) begin
        rd_req = 1'b1; rd_size = 2'd3; rd_addr = 8'h10;
        wr_req = 1'b1; wr_size = 2'd3; wr_addr = 8'h10; wr_data = 32'hFFFF_FFFF;
      end
      if (i == 20) begin
        rd_req = 1'b0;
        wr_req = 1'b0;
      end
      cyc(1);
      if (!rd_busy || !wr_busy) busy_drop = 1'b1;
      if (rd_ready || wr_ready) rdy_seen = 1'b1;
      if (init_done) early_done = 1'b1;
    end
    chk1("init_busy_held", busy_drop, 1'b0);
    chk1("init_no_ready", rdy_seen, 1'b0);
    chk1("init_not_early", early_done, 1'b0);
    cyc(1);
    chk1("init_done_rise", init_done, 1'b1);
    chk1("run_rd_idle", rd_busy, 1'b0);
    chk1("run_wr_idle", wr_busy, 1'b0);

    do_read(8'h10, 2'd3, 32'h0000_0000, "rd10_zero");

    do_write(8'h20, 2'd3, 32'hDEAD_BEEF, "wr20");
    do_read(8'h21, 2'd1, 32'h0000_00BE, "rd21_b");
    do_read(8'h22, 2'd2, 32'h0000_DEAD, "rd22_h");
    do_read(8'h20, 2'd3, 32'hDEAD_BEEF, "rd20_w");
    do_read(8'h24, 2'd1, 32'h0000_0000, "rd24_b");

    do_write(8'hFE, 2'd3, 32'h1122_3344, "wrFE_wrap");
    do_read(8'h00, 2'd2, 32'h0000_1122, "rd00_h");
    do_read(8'hFF, 2'd1, 32'h0000_0033, "rdFF_b");
    do_read(8'hFE, 2'd3, 32'h1122_3344, "rdFE_w");

    do_write(8'h50, 2'd2, 32'h9999_ABCD, "wr50_h");
    do_read(8'h50, 2'd3, 32'h0000_ABCD, "rd50_h");
    do_write(8'h52, 2'd1, 32'h1234_5677, "wr52_b");
    do_read(8'h50, 2'd3, 32'h0077_ABCD, "rd50_hb");

    // Read and write land on the same edge; overlap bytes come from the write.
    rd_req  = 1'b1; rd_addr = 8'h40; rd_size = 2'd3;
    cyc(1);
    rd_req  = 1'b0;
    wr_req  = 1'b1; wr_addr = 8'h42; wr_size = 2'd3; wr_data = 32'hCAFE_F00D;
    cyc(1);
    wr_req  = 1'b0;
    chk1("fwd_rd_early", rd_ready, 1'b0);
    chk1("fwd_wr_early", wr_ready, 1'b0);
    cyc(1);
    chk1("fwd_rd_rdy", rd_ready, 1'b1);
    chk1("fwd_wr_rdy", wr_ready, 1'b1);
    chk32("fwd_rd_data", rd_data, 32'hF00D_0000);
    cyc(3);
    chk32("fwd_rd_hold", rd_data, 32'hF00D_0000);
    do_read(8'h42, 2'd3, 32'hCAFE_F00D, "rd42_w");

    // Zero-size read is ignored.
    rd_req = 1'b1; rd_addr = 8'h20; rd_size = 2'd0;
    cyc(1);
    chk1("sz0_rd_busy", rd_busy, 1'b0);
    cyc(3);
    chk1("sz0_rd_ready", rd_ready, 1'b0);
    chk32("sz0_rd_data", rd_data, 32'hCAFE_F00D);
    rd_req = 1'b0;

    // Request held while busy must not start a second write.
    wr_req = 1'b1; wr_addr = 8'h60; wr_size = 2'd3; wr_data = 32'h1234_5678;
    cyc(1);
    chk1("busy_wr_busy", wr_busy, 1'b1);
    wr_addr = 8'h70; wr_data = 32'hFFFF_FFFF;
    cyc(1);
    chk1("busy_wr_first_rdy", wr_ready, 1'b1);
    cyc(1);
    wr_req = 1'b0;
    chk1("busy_wr_idle", wr_busy, 1'b0);
    cyc(2);
    chk1("busy_wr_no_rdy", wr_ready, 1'b0);
    do_read(8'h70, 2'd3, 32'h0000_0000, "rd70_untouched");

    // Zero-size write is ignored.
    wr_req = 1'b1; wr_addr = 8'h60; wr_size = 2'd0; wr_data = 32'h0;
    cyc(1);
    chk1("sz0_wr_busy", wr_busy, 1'b0);
    cyc(2);
    chk1("sz0_wr_ready", wr_ready, 1'b0);
    wr_req = 1'b0;
    do_read(8'h60, 2'd3, 32'h1234_5678, "rd60_w");

    // Reset during write WAIT discards the write and re-clears the array.
    wr_req = 1'b1; wr_addr = 8'h30; wr_size = 2'd1; wr_data = 32'h0000_0055;
    cyc(1);
    wr_req = 1'b0;
    reset  = 1'b0;
    cyc(1);
    chk1("rst2_wr_ready", wr_ready, 1'b0);
    chk1("rst2_init_done", init_done, 1'b0);
    chk32("rst2_rd_data", rd_data, 32'h0);
    chk1("rst2_wr_busy", wr_busy, 1'b1);
    reset    = 1'b1;
    rdy_seen = 1'b0;
    for (int i = 0; i < 256; i++) begin
      cyc(1);
      if (wr_ready || rd_ready) rdy_seen = 1'b1;
    end
    chk1("rst2_no_ready", rdy_seen, 1'b0);
    chk1("rst2_not_early", init_done, 1'b0);
    cyc(1);
    chk1("rst2_done", init_done, 1'b1);
    do_read(8'h30, 2'd3, 32'h0000_0000, "rd30_cleared");
    do_read(8'h20, 2'd3, 32'h0000_0000, "rd20_cleared");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
